// File: rtl/rv_pkg.sv
// Shared constants and entry layout for the fetch/decode instruction queue.
// Optional predecode fields are present only when INST_QUEUE_PREDECODE_EN is defined.
package rv_pkg;

  // Architectural word width for pc and instruction words
  localparam int unsigned XLEN = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0), shown on the output whenever the queue is empty
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Major opcodes recognised by the predecoder
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // One buffered fetch result at the default word width
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
`ifdef INST_QUEUE_PREDECODE_EN
    logic            is_jal;
    logic            is_br;
    logic [XLEN-1:0] imm;
`endif
  } entry_t;

endpackage : rv_pkg

// File: rtl/inst_queue_predecode.sv
// Combinational predecoder: flags JAL / conditional branches and extracts their
// sign-extended immediates so fetch can redirect early. Only instantiated by
// inst_queue when INST_QUEUE_PREDECODE_EN is defined.
module inst_queue_predecode
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = rv_pkg::XLEN
) (
  input  logic [XLEN-1:0] inst_i,
  output logic            is_jal_o,
  output logic            is_br_o,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0]  opcode;
  logic [20:0] j_imm;
  logic [12:0] b_imm;

  assign opcode = inst_i[6:0];

  // J-type immediate: imm[20|10:1|11|19:12] lives in inst[31:12], bit 0 is implicit zero
  assign j_imm = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // B-type immediate: imm[12|10:5] in inst[31:25], imm[4:1|11] in inst[11:7]
  assign b_imm = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

  // Classify the opcode and pick the matching sign-extended offset
  always_comb begin
    is_jal_o = 1'b0;
    is_br_o  = 1'b0;
    imm_o    = '0;
    case (opcode)
      OPC_JAL: begin
        is_jal_o = 1'b1;
        imm_o    = {{(XLEN-21){j_imm[20]}}, j_imm};
      end
      OPC_BRANCH: begin
        is_br_o = 1'b1;
        imm_o   = {{(XLEN-13){b_imm[12]}}, b_imm};
      end
      default: begin
        is_jal_o = 1'b0;
        is_br_o  = 1'b0;
        imm_o    = '0;
      end
    endcase
  end

endmodule : inst_queue_predecode

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: in-order FIFO of {pc, inst} pairs
// with valid/ready on both sides and a single-cycle flush for redirects.
// Optional feature macro: INST_QUEUE_PREDECODE_EN adds predecoded jal/branch
// flags and immediate, computed at push time and stored with each entry.
module inst_queue
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = rv_pkg::XLEN,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   sclk_i,
  input  logic                   srst_n_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [XLEN-1:0]        in_pc_i,
  input  logic [XLEN-1:0]        in_inst_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [XLEN-1:0]        out_pc_o,
  output logic [XLEN-1:0]        out_inst_o,
`ifdef INST_QUEUE_PREDECODE_EN
  output logic                   out_is_jal_o,
  output logic                   out_is_br_o,
  output logic [XLEN-1:0]        out_imm_o,
`endif
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [XLEN-1:0] NOP_WORD = XLEN'(NOP_INST);

  // Entry layout at this instance's word width
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
`ifdef INST_QUEUE_PREDECODE_EN
    logic            is_jal;
    logic            is_br;
    logic [XLEN-1:0] imm;
`endif
  } q_entry_t;

  // Storage is deliberately left unreset; the empty-mux below hides stale contents
  q_entry_t mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic     is_full;
  logic     is_empty;
  logic     push;
  logic     pop;
  q_entry_t wr_entry;
  q_entry_t head_entry;

  // Occupancy flags and handshakes; a flush blocks fetch for that cycle and a
  // full queue refuses a push even when decode pops in the same cycle
  always_comb begin
    is_full     = (count_q == FULL_COUNT);
    is_empty    = (count_q == '0);
    in_ready_o  = ~is_full & ~flush_i;
    out_valid_o = ~is_empty;
    push        = in_valid_i & in_ready_o;
    pop         = out_valid_o & out_ready_i;
  end

`ifdef INST_QUEUE_PREDECODE_EN
  logic            pd_is_jal;
  logic            pd_is_br;
  logic [XLEN-1:0] pd_imm;

  inst_queue_predecode #(
    .XLEN (XLEN)
  ) u_predecode (
    .inst_i   (in_inst_i),
    .is_jal_o (pd_is_jal),
    .is_br_o  (pd_is_br),
    .imm_o    (pd_imm)
  );
`endif

  // Assemble the entry written on a push
  always_comb begin
    wr_entry      = '0;
    wr_entry.pc   = in_pc_i;
    wr_entry.inst = in_inst_i;
`ifdef INST_QUEUE_PREDECODE_EN
    wr_entry.is_jal = pd_is_jal;
    wr_entry.is_br  = pd_is_br;
    wr_entry.imm    = pd_imm;
`endif
  end

  // Next-state for pointers and count; flush wins over any same-cycle push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge sclk_i or negedge srst_n_i) begin
    if (!srst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port; push is already suppressed during flush
  always_ff @(posedge sclk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  // Head read is asynchronous so a pushed entry shows up the cycle after its push edge
  always_comb begin
    head_entry = mem[rd_ptr_q];
  end

  // Output mux: never expose stale or uninitialised storage when empty
  always_comb begin
    count_o    = count_q;
    out_pc_o   = is_empty ? '0 : head_entry.pc;
    out_inst_o = is_empty ? NOP_WORD : head_entry.inst;
`ifdef INST_QUEUE_PREDECODE_EN
    out_is_jal_o = is_empty ? 1'b0 : head_entry.is_jal;
    out_is_br_o  = is_empty ? 1'b0 : head_entry.is_br;
    out_imm_o    = is_empty ? '0   : head_entry.imm;
`endif
  end

endmodule : inst_queue

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model. Predecode checks are
// compiled when INST_QUEUE_PREDECODE_EN is defined.
module tb_inst_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic            sclk_i      = 1'b0;
  logic            srst_n_i    = 1'b0;
  logic            flush_i     = 1'b0;
  logic            in_valid_i  = 1'b0;
  logic            in_ready_o;
  logic [XLEN-1:0] in_pc_i     = '0;
  logic [XLEN-1:0] in_inst_i   = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [XLEN-1:0] out_pc_o;
  logic [XLEN-1:0] out_inst_o;
  logic [2:0]      count_o;
`ifdef INST_QUEUE_PREDECODE_EN
  logic            out_is_jal_o;
  logic            out_is_br_o;
  logic [XLEN-1:0] out_imm_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the queue contents in order, head at index 0
  logic [31:0] m_pc[$];
  logic [31:0] m_inst[$];

  inst_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .sclk_i      (sclk_i),
    .srst_n_i    (srst_n_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_pc_i     (in_pc_i),
    .in_inst_i   (in_inst_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_pc_o    (out_pc_o),
    .out_inst_o  (out_inst_o),
`ifdef INST_QUEUE_PREDECODE_EN
    .out_is_jal_o(out_is_jal_o),
    .out_is_br_o (out_is_br_o),
    .out_imm_o   (out_imm_o),
`endif
    .count_o     (count_o)
  );

  always #5 sclk_i = ~sclk_i;

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit do_push;
    bit do_pop;
    if (flush_i) begin
      m_pc.delete();
      m_inst.delete();
    end else begin
      do_push = in_valid_i && (m_pc.size() < DEPTH);
      do_pop  = out_ready_i && (m_pc.size() > 0);
      if (do_pop) begin
        void'(m_pc.pop_front());
        void'(m_inst.pop_front());
      end
      if (do_push) begin
        m_pc.push_back(in_pc_i);
        m_inst.push_back(in_inst_i);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge sclk_i);
    @(negedge sclk_i);
  endtask

  task automatic idle_inputs();
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
  endtask

  function automatic logic [31:0] exp_pc();
    return (m_pc.size() != 0) ? m_pc[0] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_inst();
    return (m_inst.size() != 0) ? m_inst[0] : NOP;
  endfunction

  task automatic test_reset();
    srst_n_i = 1'b0;
    idle_inputs();
    m_pc.delete();
    m_inst.delete();
    @(negedge sclk_i);
    #1;
    n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready_o); end
    n_cmp++; if (out_inst_o !== NOP) begin n_bad++; $display("FAIL reset_inst: got %h want %h", out_inst_o, NOP); end
    n_cmp++; if (out_pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", out_pc_o); end
    @(negedge sclk_i);
    srst_n_i = 1'b1;
    tick();
    n_cmp++; if (count_o !== 3'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1)
      begin n_bad++; $display("FAIL post_reset_state: got cnt=%0d v=%b r=%b want 0/0/1", count_o, out_valid_o, in_ready_o); end
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1;
      in_pc_i    = 32'(4 * i);
      in_inst_i  = 32'hA0 + 32'(i);
      tick();
    end
    idle_inputs();
    #1;
    n_cmp++; if (count_o !== 3'd4) begin n_bad++; $display("FAIL fill_count: got %0d want 4", count_o); end
    n_cmp++; if (in_ready_o !== 1'b0) begin n_bad++; $display("FAIL fill_ready: got %b want 0", in_ready_o); end
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'(4 * i) || out_inst_o !== 32'hA0 + 32'(i))
        begin n_bad++; $display("FAIL drain_head[%0d]: got v=%b pc=%h inst=%h want 1/%h/%h", i, out_valid_o, out_pc_o, out_inst_o, 4 * i, 32'hA0 + i); end
      tick();
    end
    idle_inputs();
    #1;
    n_cmp++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got cnt=%0d v=%b want 0/0", count_o, out_valid_o); end
    $display("test_fill_drain done");
  endtask

  task automatic test_streaming();
    in_valid_i = 1'b1;
    in_pc_i    = 32'h0;
    in_inst_i  = 32'h1000;
    tick();
    out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pc_i   = 32'(4 * (i + 1));
      in_inst_i = 32'h1000 + 32'(i + 1);
      #1;
      n_cmp++; if (count_o !== 3'd1 || out_pc_o !== 32'(4 * i) || out_inst_o !== 32'h1000 + 32'(i))
        begin n_bad++; $display("FAIL stream[%0d]: got cnt=%0d pc=%h inst=%h want 1/%h/%h", i, count_o, out_pc_o, out_inst_o, 4 * i, 32'h1000 + i); end
      tick();
    end
    in_valid_i = 1'b0;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL stream_end_count: got %0d want 0", count_o); end
    $display("test_streaming done");
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1;
      in_pc_i    = 32'h200 + 32'(4 * i);
      in_inst_i  = 32'hB0 + 32'(i);
      tick();
    end
    in_valid_i  = 1'b1;
    in_pc_i     = 32'h999;
    in_inst_i   = 32'h999;
    out_ready_i = 1'b1;
    #1;
    n_cmp++; if (in_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_pop_ready: got %b want 0", in_ready_o); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (count_o !== 3'd3) begin n_bad++; $display("FAIL full_pop_count: got %0d want 3", count_o); end
    out_ready_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      n_cmp++; if (out_pc_o !== 32'h200 + 32'(4 * i) || out_pc_o !== exp_pc())
        begin n_bad++; $display("FAIL full_pop_drain[%0d]: got pc=%h want %h", i, out_pc_o, 32'h200 + 4 * i); end
      tick();
    end
    idle_inputs();
    #1;
    n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL full_pop_end: got %0d want 0", count_o); end
    $display("test_full_pop done");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1;
      in_pc_i    = 32'h300 + 32'(4 * i);
      in_inst_i  = 32'hC0 + 32'(i);
      tick();
    end
    flush_i     = 1'b1;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    in_pc_i     = 32'h3F0;
    #1;
    n_cmp++; if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1)
      begin n_bad++; $display("FAIL flush_cycle: got r=%b v=%b want 0/1", in_ready_o, out_valid_o); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (count_o !== 3'd0 || out_valid_o !== 1'b0 || out_inst_o !== NOP)
      begin n_bad++; $display("FAIL flush_after: got cnt=%0d v=%b inst=%h want 0/0/%h", count_o, out_valid_o, out_inst_o, NOP); end
    in_valid_i = 1'b1;
    in_pc_i    = 32'h100;
    in_inst_i  = 32'hD0;
    #1;
    n_cmp++; if (out_valid_o !== 1'b0 || out_pc_o !== 32'h0)
      begin n_bad++; $display("FAIL flush_no_bypass: got v=%b pc=%h want 0/0", out_valid_o, out_pc_o); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h100 || out_inst_o !== 32'hD0)
      begin n_bad++; $display("FAIL flush_refill: got v=%b pc=%h inst=%h want 1/100/d0", out_valid_o, out_pc_o, out_inst_o); end
    out_ready_i = 1'b1;
    tick();
    idle_inputs();
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1'b1;
      in_pc_i    = 32'h500 + 32'(4 * i);
      in_inst_i  = 32'hE0 + 32'(i);
      tick();
    end
    idle_inputs();
    #2;
    srst_n_i = 1'b0;
    m_pc.delete();
    m_inst.delete();
    #1;
    n_cmp++; if (count_o !== 3'd0 || out_valid_o !== 1'b0 || out_inst_o !== NOP || in_ready_o !== 1'b1)
      begin n_bad++; $display("FAIL async_reset: got cnt=%0d v=%b inst=%h r=%b want 0/0/%h/1", count_o, out_valid_o, out_inst_o, in_ready_o, NOP); end
    @(negedge sclk_i);
    srst_n_i = 1'b1;
    tick();
    $display("test_async_reset done");
  endtask

`ifdef INST_QUEUE_PREDECODE_EN
  task automatic test_predecode();
    #1;
    n_cmp++; if (out_is_jal_o !== 1'b0 || out_is_br_o !== 1'b0 || out_imm_o !== 32'h0)
      begin n_bad++; $display("FAIL pd_empty: got jal=%b br=%b imm=%h want 0/0/0", out_is_jal_o, out_is_br_o, out_imm_o); end
    in_valid_i = 1'b1;
    in_pc_i    = 32'h40;
    in_inst_i  = 32'h008000EF;
    tick();
    in_pc_i     = 32'h44;
    in_inst_i   = 32'hFE000EE3;
    #1;
    n_cmp++; if (out_is_jal_o !== 1'b1 || out_is_br_o !== 1'b0 || out_imm_o !== 32'h8)
      begin n_bad++; $display("FAIL pd_jal: got jal=%b br=%b imm=%h want 1/0/8", out_is_jal_o, out_is_br_o, out_imm_o); end
    out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    #1;
    n_cmp++; if (out_is_br_o !== 1'b1 || out_is_jal_o !== 1'b0 || out_imm_o !== 32'hFFFF_FFFC)
      begin n_bad++; $display("FAIL pd_br: got jal=%b br=%b imm=%h want 0/1/fffffffc", out_is_jal_o, out_is_br_o, out_imm_o); end
    tick();
    idle_inputs();
    $display("test_predecode done");
  endtask
`endif

  task automatic test_random();
    int bad_before;
    bad_before = n_bad;
    for (int c = 0; c < 400; c++) begin
      flush_i     = ($urandom_range(0, 19) == 0);
      in_valid_i  = (c < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      out_ready_i = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      in_pc_i     = $urandom;
      in_inst_i   = $urandom;
      #1;
      n_cmp++; if (count_o !== 3'(m_pc.size()))
        begin n_bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, count_o, m_pc.size()); end
      n_cmp++; if (in_ready_o !== ((m_pc.size() != DEPTH) && !flush_i))
        begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, in_ready_o, (m_pc.size() != DEPTH) && !flush_i); end
      n_cmp++; if (out_valid_o !== (m_pc.size() != 0) || out_pc_o !== exp_pc() || out_inst_o !== exp_inst())
        begin n_bad++; $display("FAIL rnd_head[%0d]: got v=%b pc=%h inst=%h want %b/%h/%h", c, out_valid_o, out_pc_o, out_inst_o, m_pc.size() != 0, exp_pc(), exp_inst()); end
      tick();
    end
    idle_inputs();
    $display("test_random done: %0d new mismatches", n_bad - bad_before);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_full_pop();
    test_flush();
    test_async_reset();
`ifdef INST_QUEUE_PREDECODE_EN
    test_predecode();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_inst_queue
